// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the mem_arbiter slice.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (fixed lowest-index priority).
package mem_arb_pkg;

  localparam int DEF_DW   = 8;
  localparam int DEF_AW   = 5;
  localparam int DEF_NREQ = 2;

  // Tracker ids are stored at this fixed width so the entry type can live here.
  localparam int MAX_IDW  = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } trk_entry_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester command/response channels plus the memory-side bus of mem_arbiter.
// slave = the arbiter; master = requesters and the memory model.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int NREQ = DEF_NREQ
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [DW-1:0]      mem_data_in;
  logic [AW-1:0]      mem_addr;
  logic               mem_write;
  logic               mem_read;
  logic [DW-1:0]      mem_data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_data,
    output mem_data_in, mem_addr, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_data_in, mem_addr, mem_write, mem_read
  );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant generator: round-robin from prio_ptr, or fixed lowest-index
// priority when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
      end
    end
  end

  // No pointer state in this build; these inputs only exist for port parity.
  logic unused_inputs;
  assign unused_inputs = ^{CLK, RST, advance};

`else

  localparam int IDW = id_width(NREQ);

  logic [IDW-1:0] prio_ptr;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] next_ptr;
  logic           found;
  int             idx;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(prio_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_idx  = IDW'(idx);
      end
    end
  end

  assign next_ptr = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments and a synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_ptr <= '0;
    end else if (advance) begin
      prio_ptr <= next_ptr;
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory among NREQ requesters; registered
// memory commands and in-order read responses. Honours MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW,
  parameter int NREQ = DEF_NREQ
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0] gnt;
  logic            transfer;
  op_e             sel_op;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [IDW-1:0]  sel_id;
  trk_entry_t      stage1;
  trk_entry_t      stage2;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (bus.req_valid),
    .advance (transfer),
    .gnt     (gnt)
  );

  // Grants are held off while RST is high so nothing transfers during reset.
  assign bus.req_ready = RST ? '0 : gnt;
  assign transfer      = |bus.req_ready;

  always_comb begin
    sel_op    = OP_READ;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        sel_op    = bus.req_write[i] ? OP_WRITE : OP_READ;
        sel_addr  = bus.req_addr[i*AW +: AW];
        sel_wdata = bus.req_wdata[i*DW +: DW];
        sel_id    = IDW'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.mem_write   <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_data_in <= '0;
    end else if (transfer) begin
      bus.mem_write   <= (sel_op == OP_WRITE);
      bus.mem_read    <= (sel_op == OP_READ);
      bus.mem_addr    <= sel_addr;
      bus.mem_data_in <= sel_wdata;
    end else begin
      bus.mem_write   <= 1'b0;
      bus.mem_read    <= 1'b0;
    end
  end

  // Stage 1 lines up with the memory command, stage 2 with memory data_out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= '{valid: transfer && (sel_op == OP_READ), id: MAX_IDW'(sel_id)};
      stage2 <= stage1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= '0;
      if (stage2.valid) begin
        bus.rsp_data <= bus.mem_data_out;
        for (int i = 0; i < NREQ; i++) begin
          if (stage2.id == MAX_IDW'(i)) bus.rsp_valid[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, reference memory and a
// response scoreboard. Define MEM_ARB_FIXED_PRIO_EN to exercise the fixed build.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int NREQ = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.DW(DW), .AW(AW), .NREQ(NREQ)) bus ();

  mem_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Single-port synchronous memory with registered data_out.
  logic [DW-1:0] mem_array [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (bus.mem_write) mem_array[bus.mem_addr] <= bus.mem_data_in;
    if (bus.mem_read)  bus.mem_data_out <= mem_array[bus.mem_addr];
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  // Grants feed the reference memory and scoreboard; responses are popped here.
  always @(negedge CLK) begin : monitor
    logic [AW-1:0]   a;
    exp_t            e;
    logic [NREQ-1:0] exp_vec;
    if (bus.rsp_valid !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp cyc=%0d rsp_valid=%b rsp_data=%h expected no response",
                 cyc, bus.rsp_valid, bus.rsp_data);
      end else begin
        e       = sb.pop_front();
        exp_vec = NREQ'(1) << e.id;
        if (bus.rsp_valid !== exp_vec || bus.rsp_data !== e.data || cyc != e.due) begin
          failures++;
          $display("FAIL rsp cyc=%0d got valid=%b data=%h, expected valid=%b data=%h at cyc=%0d",
                   cyc, bus.rsp_valid, bus.rsp_data, exp_vec, e.data, e.due);
        end
      end
    end
    if (!RST) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          a = bus.req_addr[i*AW +: AW];
          if (bus.req_write[i]) ref_mem[a] = bus.req_wdata[i*DW +: DW];
          else sb.push_back('{i, ref_mem[a], cyc + 3});
        end
      end
    end
  end

  task automatic drive(input int i, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.req_valid[i]           = 1'b1;
    bus.req_write[i]           = wr;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  // Returns on the negedge preceding the transfer edge.
  task automatic wait_grant(input int i, input string tag);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge CLK);
      if (bus.req_valid[i] && bus.req_ready[i]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s grant_timeout req=%0d got no grant, expected grant within 20 cycles", tag, i);
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s rsp_missing outstanding=%0d expected 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.mem_write, bus.mem_read,
           bus.mem_addr, bus.mem_data_in} !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d ready=%b rsp_v=%b rsp_d=%h w=%b r=%b addr=%h din=%h expected all 0",
                 cyc, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.mem_write,
                 bus.mem_read, bus.mem_addr, bus.mem_data_in);
      end
    end
  endtask

  task automatic test_write_read();
    @(posedge CLK); #1;
    drive(0, 1'b1, 5'd3, 8'hA5);
    wait_grant(0, "wr3");
    @(posedge CLK); #1 bus.req_valid[0] = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 5'd3 ||
        bus.mem_data_in !== 8'hA5) begin
      failures++;
      $display("FAIL write_issue w=%b r=%b addr=%h din=%h expected w=1 r=0 addr=03 din=a5",
               bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_data_in);
    end
    @(posedge CLK); #1;
    drive(0, 1'b0, 5'd3, 8'h00);
    wait_grant(0, "rd3");
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_addr !== 5'd3 ||
        bus.mem_data_in !== 8'hA5) begin
      failures++;
      $display("FAIL idle_hold w=%b r=%b addr=%h din=%h expected w=0 r=0 addr=03 din=a5",
               bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_data_in);
    end
    @(posedge CLK); #1 bus.req_valid[0] = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_addr !== 5'd3) begin
      failures++;
      $display("FAIL read_issue w=%b r=%b addr=%h expected w=0 r=1 addr=03",
               bus.mem_write, bus.mem_read, bus.mem_addr);
    end
    drain("write_read");
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp_rdy;
    @(posedge CLK); #1;
    drive(0, 1'b1, 5'd1, 8'h11);
    wait_grant(0, "pre1");
    @(posedge CLK); #1 bus.req_valid[0] = 1'b0;
    drive(1, 1'b1, 5'd2, 8'h22);
    wait_grant(1, "pre2");
    @(posedge CLK); #1 bus.req_valid[1] = 1'b0;
    drive(0, 1'b0, 5'd1, 8'h00);
    drive(1, 1'b0, 5'd2, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_rdy = 2'b01;
`else
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL grant_seq k=%0d req_ready=%b expected %b", k, bus.req_ready, exp_rdy);
      end
    end
    @(posedge CLK); #1 bus.req_valid = '0;
    drain("back_to_back");
  endtask

  task automatic test_write_then_read();
    @(posedge CLK); #1;
    drive(1, 1'b1, 5'd7, 8'h5C);
    wait_grant(1, "wr7");
    @(posedge CLK); #1 bus.req_valid[1] = 1'b0;
    drive(0, 1'b0, 5'd7, 8'h00);
    @(negedge CLK);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL consecutive_grant req_ready=%b expected 01", bus.req_ready);
    end
    @(posedge CLK); #1 bus.req_valid[0] = 1'b0;
    drain("write_then_read");
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1;
    drive(0, 1'b0, 5'd1, 8'h00);
    wait_grant(0, "rd_pre_rst");
    @(posedge CLK); #1;
    RST = 1'b1;
    sb.delete();
    drive(0, 1'b0, 5'd1, 8'h00);
    drive(1, 1'b0, 5'd2, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.req_ready !== 2'b00) begin
        failures++;
        $display("FAIL ready_in_reset k=%0d req_ready=%b expected 00", k, bus.req_ready);
      end
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_grant req_ready=%b expected 01", bus.req_ready);
    end
    @(posedge CLK); #1 bus.req_valid[0] = 1'b0;
    wait_grant(1, "post_rst_req1");
    @(posedge CLK); #1 bus.req_valid[1] = 1'b0;
    drain("reset_mid");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_then_read();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
